imm_instr_encoder: RTL and testbench
====================================

Name: imm_instr_encoder

Overview:
- Inverse of the core's immediate extraction path: packs format, register indices, funct3 and a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Range- and alignment-checks the immediate; illegal requests emit a NOP and raise an error flag.
- Used by the test-program generator and the self-modifying-code/trampoline writer ahead of instruction memory.
- Valid/ready input, registered encode stage, small output FIFO, saturating statistics counters.

Parameters:
- FIFO_DEPTH, 2: output queue entries; power of two, at least 2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fmt  in  3  format: 0 I-ALU (0010011), 1 Load (0000011), 2 Store (0100011), 3 Branch (1100011), 4 U/LUI (0110111, optional), 5 J/JAL (1101111, optional); 6 and 7 are illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_imm  in  32  signed immediate, byte offset for Branch/J.
- out_valid  out  1  out_instr valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded instruction.
- out_err  out  1  this beat was illegal; out_instr is the NOP.
- enc_count  out  CNT_W  accepted requests.
- err_count  out  CNT_W  illegal requests.

Behaviour:
- Reset: with rst_n low at a clk edge, the FIFO is flushed, out_valid=0, out_instr=0, out_err=0 and both counters are 0.
- Reset: in_ready=0 while rst_n is low; in_ready=1 on the first cycle after release.
- Reset mid-operation discards all queued beats and any in-flight encode.
- Handshake: in_ready = !fifo_full, registered state only. When full, no push occurs even if a pop happens in the same cycle.
- Output beat: held stable while out_valid && !out_ready.
- FIFO order: strictly in acceptance order.
- Latency: an accepted request is visible on out_instr/out_valid on the next cycle when the FIFO is empty.
- Throughput: 1 beat/cycle sustained with out_ready high.
- I/Load legal range: imm in [-2048, 2047]. Encoding: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode. rs2 is ignored.
- Store legal range: imm in [-2048, 2047]. Encoding: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0]. rd is ignored.
- Branch legal range: imm in [-4096, 4094] and imm[0]=0. Encoding: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11]. rd is ignored.
- Range check: performed on the full 32-bit signed value; upper bits must be pure sign extension.
- Illegal request (bad fmt, out of range, or misaligned): out_instr=32'h0000_0013 (addi x0,x0,0), out_err=1; the beat is still queued and still counted.
- Counters: enc_count increments on every accept; err_count on every illegal accept. Both saturate at all-ones and never wrap.

Optional Feature:
- Macro: IMM_ENC_UJ_EN.
- When defined, fmt 4 (U/LUI): legal iff imm[11:0]=0; encoding [31:12]=imm[31:12], [11:7]=rd.
- When defined, fmt 5 (J/JAL): legal iff imm in [-1048576, 1048574] and imm[0]=0. Encoding: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
- When not defined, fmt 4 and 5 are illegal (NOP + err) and no U/J logic is synthesized.

Test Plan:
- I-ALU: fmt=0, rd=1, rs1=2, funct3=0, imm=-1, out_ready=1 -> next cycle out_instr=0xFFF10093, out_err=0, enc_count=1.
- Store: fmt=2, rs1=6, rs2=5, funct3=2, imm=8 -> out_instr=0x00532423. Branch: fmt=3, rs1=1, rs2=2, funct3=0, imm=-4 -> out_instr=0xFE208EE3.
- Illegal: fmt=0 imm=2048, fmt=3 imm=5, fmt=7 -> three beats, each out_instr=0x00000013 with out_err=1; err_count=3. With IMM_ENC_UJ_EN undefined, fmt=5 -> NOP + err.
- Backpressure: out_ready=0, offer 3 beats with FIFO_DEPTH=2 -> in_ready drops after 2 accepts and the 3rd is held. Raise out_ready -> 3 beats in original order, out_instr stable while stalled.
- Reset: 2 beats queued, rst_n=0 for one edge -> out_valid=0, out_instr=0, counters=0, in_ready=1 the cycle after release.
- Saturation (CNT_W=4): 17 illegal accepts -> enc_count=15, err_count=15. With IMM_ENC_UJ_EN defined, fmt=5 rd=1 imm=8 -> out_instr=0x008000EF.

Source files
------------

// File: rtl/imm_instr_encoder.sv
// RV32I immediate-format instruction encoder: request handshake, range/alignment
// checks, output FIFO and saturating counters. Optional U/J support: IMM_ENC_UJ_EN.
module imm_instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_err,
  output logic [CNT_W-1:0]  enc_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 33;

  localparam logic [6:0]  OPC_I   = 7'b0010011;
  localparam logic [6:0]  OPC_LD  = 7'b0000011;
  localparam logic [6:0]  OPC_ST  = 7'b0100011;
  localparam logic [6:0]  OPC_BR  = 7'b1100011;
`ifdef IMM_ENC_UJ_EN
  localparam logic [6:0]  OPC_LUI = 7'b0110111;
  localparam logic [6:0]  OPC_JAL = 7'b1101111;
`endif
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic signed [31:0] w_imm_s;
  logic               w_imm12_ok;
  logic               w_br_ok;
  logic               w_legal;
  logic [31:0]        w_word;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_count_nxt;
  logic [EW-1:0]      w_head;

  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_enc_count;
  logic [CNT_W-1:0]   r_err_count;

  // Range checks run on the full 32-bit value, so upper bits must be sign extension.
  assign w_imm_s    = $signed(in_imm);
  assign w_imm12_ok = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
  assign w_br_ok    = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !in_imm[0];

  always_comb begin
    w_legal = 1'b0;
    w_word  = NOP;
    case (in_fmt)
      3'd0: begin
        w_legal = w_imm12_ok;
        w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_I};
      end
      3'd1: begin
        w_legal = w_imm12_ok;
        w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LD};
      end
      3'd2: begin
        w_legal = w_imm12_ok;
        w_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_ST};
      end
      3'd3: begin
        w_legal = w_br_ok;
        w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], OPC_BR};
      end
`ifdef IMM_ENC_UJ_EN
      3'd4: begin
        w_legal = (in_imm[11:0] == 12'd0);
        w_word  = {in_imm[31:12], in_rd, OPC_LUI};
      end
      3'd5: begin
        w_legal = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574) && !in_imm[0];
        w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
`endif
      default: ;
    endcase
    if (!w_legal) w_word = NOP;
  end

  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = r_out_valid && out_ready;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Encoded beat is written straight into the FIFO; the head entry drives the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem       <= '{default: '0};
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_enc_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {!w_legal, w_word};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
        if (r_enc_count != CNT_MAX) r_enc_count <= r_enc_count + CNT_W'(1);
        if (!w_legal && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + CNT_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != CW'(FIFO_DEPTH));
      r_out_valid <= (w_count_nxt != CW'(0));
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = w_head[31:0];
  assign out_err   = w_head[32];
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder: directed examples plus random requests
// checked against an arithmetic reference model.
module tb_imm_instr_encoder;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2;
  localparam int          CMAX  = 15;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_err    = 0;
  int ready_mode = 0;
  logic [32:0] q[$];

  imm_instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer: 0 = stall, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference encoder built from field arithmetic on the spec's bit layouts.
  function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [31:0] imm);
    int s;
    logic [31:0] u, w, d, r1, r2, f;
    bit ok;
    s = $signed(imm);
    u = imm;
    d = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2); f = 32'(f3);
    ok = 0;
    w = 32'h13;
    case (fmt)
      3'd0, 3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w = ((u & 32'hFFF) << 20) | (r1 << 15) | (f << 12) | (d << 7) |
            ((fmt == 3'd0) ? 32'h13 : 32'h03);
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f << 12) |
            ((u & 32'h1F) << 7) | 32'h23;
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20) |
            (r1 << 15) | (f << 12) | (((u >> 1) & 32'hF) << 8) |
            (((u >> 11) & 1) << 7) | 32'h63;
      end
`ifdef IMM_ENC_UJ_EN
      3'd4: begin
        ok = ((u & 32'hFFF) == 0);
        w = (u & 32'hFFFF_F000) | (d << 7) | 32'h37;
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
            (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
      end
`endif
      default: ok = 0;
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every presented beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got err=%0b instr=%08h, none expected", out_err, out_instr);
      end else begin
        if ({out_err, out_instr} !== q[0]) begin
          n_fail++;
          $display("FAIL beat: got err=%0b instr=%08h expected err=%0b instr=%08h",
                   out_err, out_instr, q[0][32], q[0][31:0]);
        end
        if (out_ready === 1'b1) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Waits (bounded) for the accept and records the expected beat; returns at posedge+1.
  task automatic wait_accept(input logic [32:0] exp);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        q.push_back(exp);
        n_acc++;
        if (exp[32]) n_err++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL accept_timeout: got no accept, expected in_ready within 100 cycles");
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                       input logic [32:0] exp);
    drive(fmt, rd, rs1, rs2, f3, imm);
    wait_accept(exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL drain_timeout: got %0d beats left, expected 0", q.size());
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_enc_count"}, 64'(enc_count), 64'(sat(n_acc)));
    check({tag, "_err_count"}, 64'(err_count), 64'(sat(n_err)));
  endtask

  function automatic logic [31:0] rand_imm();
    int k;
    logic [31:0] b[10];
    b = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF, 32'hFFFF_F000,
          32'h0000_0FFE, 32'h0000_1000, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000};
    k = int'($urandom_range(0, 4));
    case (k)
      0: return $urandom;
      1: return 32'($signed(int'($urandom_range(0, 10000)) - 5000));
      2: return b[$urandom_range(0, 9)];
      3: return 32'($signed(int'($urandom_range(0, 2200000)) - 1100000));
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  initial begin
    logic [2:0] f;
    logic [4:0] a, b, c;
    logic [2:0] g;
    logic [31:0] im;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
    check("rst_in_ready_low", 64'(in_ready), 64'(0));
    check_counters("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready_release", 64'(in_ready), 64'(1));

    // Directed legal encodings with one-cycle latency
    ready_mode = 1;
    @(posedge clk); #1;
    issue(3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF, {1'b0, 32'hFFF1_0093});
    check("latency_out_valid", 64'(out_valid), 64'(1));
    check_counters("ialu");
    issue(3'd2, 5'd0, 5'd6, 5'd5, 3'd2, 32'd8, {1'b0, 32'h0053_2423});
    issue(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC, {1'b0, 32'hFE20_8EE3});

    // Illegal requests
    issue(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 32'd2048, {1'b1, 32'h13});
    issue(3'd3, 5'd1, 5'd2, 5'd3, 3'd0, 32'd5, {1'b1, 32'h13});
    issue(3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, {1'b1, 32'h13});
`ifdef IMM_ENC_UJ_EN
    issue(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, {1'b0, 32'h0080_00EF});
`else
    issue(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, {1'b1, 32'h13});
`endif
    drain();
    check_counters("illegal");

    // Backpressure: third request held while the FIFO is full
    ready_mode = 0;
    @(posedge clk); #2;
    issue(3'd0, 5'd3, 5'd4, 5'd0, 3'd1, 32'd100, ref_enc(3'd0, 5'd3, 5'd4, 5'd0, 3'd1, 32'd100));
    issue(3'd1, 5'd7, 5'd8, 5'd0, 3'd2, 32'hFFFF_F800,
          ref_enc(3'd1, 5'd7, 5'd8, 5'd0, 3'd2, 32'hFFFF_F800));
    check("bp_in_ready_full", 64'(in_ready), 64'(0));
    drive(3'd2, 5'd0, 5'd9, 5'd10, 3'd0, 32'd2047);
    repeat (3) @(negedge clk);
    check("bp_in_ready_held", 64'(in_ready), 64'(0));
    ready_mode = 1;
    wait_accept(ref_enc(3'd2, 5'd0, 5'd9, 5'd10, 3'd0, 32'd2047));
    drain();
    check_counters("bp");

    // Reset mid-operation discards queued beats
    ready_mode = 0;
    @(posedge clk); #2;
    issue(3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 32'd1, ref_enc(3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 32'd1));
    issue(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 32'd1, {1'b1, 32'h13});
    rst_n = 1'b0;
    q.delete(); n_acc = 0; n_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_instr", 64'(out_instr), 64'(0));
    check_counters("mid_rst");
    @(posedge clk); #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));

    // Counter saturation
    ready_mode = 1;
    for (int i = 0; i < 17; i++) issue(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, {1'b1, 32'h13});
    drain();
    check("sat_enc_count", 64'(enc_count), 64'(15));
    check("sat_err_count", 64'(err_count), 64'(15));

    // Randomized requests with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      f = 3'($urandom_range(0, 7));
      a = 5'($urandom); b = 5'($urandom); c = 5'($urandom); g = 3'($urandom);
      im = rand_imm();
      issue(f, a, b, c, g, im, ref_enc(f, a, b, c, g, im));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    drain();
    check_counters("rand");
    check("final_out_valid", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
